fb_flip_ctrl: RTL and testbench

Double-buffer page-flip controller and front-buffer read-address generator for the MTL display path. Sits between the renderer (which draws into the back buffer and requests flips) and the LCD timing generator/SDRAM reader. It swaps front and back buffers only at the end-of-frame pulse, so the panel never shows a torn frame. It also converts the timing generator's look-ahead pixel coordinates into linear SDRAM word addresses in the current front buffer.

---
 rtl/fb_flip_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_fb_flip_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_flip_ctrl.sv
// -----------------------------------------------------------------------------
// fb_flip_ctrl
//
// Double-buffer page-flip controller and front-buffer read-address generator
// for the MTL display path. The renderer draws into the back buffer and pulses
// iSWAP_REQ when it is done. The front and back buffers are swapped only on
// iEnd_Frame, so the panel never shows a torn frame. The block also converts
// the timing generator's look-ahead pixel coordinates into linear SDRAM word
// addresses inside the current front buffer.
//
// Optional feature macro: FB_FLIP_INTERVAL_EN
//   When defined, the block adds a 2-bit input iSWAP_INTERVAL. A flip is then
//   allowed only once enough iEnd_Frame pulses have been seen since the
//   previous flip (a value of 0 behaves as 1). When undefined, every iEnd_Frame
//   seen while a request is pending performs the flip.
//
// Ports:
//   iCLK             LCD pixel clock
//   iRST             synchronous, active-high reset
//   iNew_Frame       one-cycle frame-start pulse (advances oFRAME_CNT)
//   iEnd_Frame       one-cycle pulse after the last visible pixel (flip point)
//   iDISPLAY_ACTIVE  next-pixel-visible flag, delayed to form oRD_EN
//   iNEXT2_X         look-ahead x coordinate, 0..H_ACTIVE-1
//   iNEXT2_Y         look-ahead y coordinate, 0..V_ACTIVE-1
//   iSWAP_INTERVAL   minimum frames between flips (FB_FLIP_INTERVAL_EN only)
//   iSWAP_REQ        one-cycle pulse: back buffer complete
//   oSWAP_ACK        one-cycle pulse: flip performed
//   oBACK_READY      renderer may write the back buffer
//   oFRONT_IDX       buffer index being displayed
//   oBACK_IDX        buffer index for rendering (always ~oFRONT_IDX)
//   oRD_ADDR         SDRAM read word address (registered)
//   oRD_EN           read strobe qualifying oRD_ADDR (registered)
//   oFRAME_CNT       count of iNew_Frame pulses, wraps to 0
// -----------------------------------------------------------------------------
module fb_flip_ctrl #(
  parameter int                H_ACTIVE  = 800,
  parameter int                V_ACTIVE  = 480,
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BUF0_BASE = 24'h000000,
  parameter logic [ADDR_W-1:0] BUF1_BASE = 24'h060000
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iNew_Frame,
  input  logic              iEnd_Frame,
  input  logic              iDISPLAY_ACTIVE,
  input  logic [10:0]       iNEXT2_X,
  input  logic [9:0]        iNEXT2_Y,
`ifdef FB_FLIP_INTERVAL_EN
  input  logic [1:0]        iSWAP_INTERVAL,
`endif
  input  logic              iSWAP_REQ,
  output logic              oSWAP_ACK,
  output logic              oBACK_READY,
  output logic              oFRONT_IDX,
  output logic              oBACK_IDX,
  output logic [ADDR_W-1:0] oRD_ADDR,
  output logic              oRD_EN,
  output logic [15:0]       oFRAME_CNT
);

  // Row stride as a bit vector; each set bit contributes one shifted copy of y.
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE);
  localparam logic [10:0]       X_MAX  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]        Y_MAX  = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_FLIP    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                front_q, front_d;
  logic                ack_q, ack_d;
  logic                back_ready_q, back_ready_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                flip_ok_s;

  // y * H_ACTIVE built from shifts and adds. For H_ACTIVE=800 this reduces to
  // (y<<9) + (y<<8) + (y<<5); the sum is truncated to ADDR_W.
  function automatic logic [ADDR_W-1:0] mul_stride(input logic [9:0] y);
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] y_ext;
    acc   = {ADDR_W{1'b0}};
    y_ext = {{(ADDR_W-10){1'b0}}, y};
    for (int i = 0; i < ADDR_W; i++) begin
      if (STRIDE[i]) begin
        acc = acc + (y_ext << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

`ifdef FB_FLIP_INTERVAL_EN
  // End-of-frame pulses seen since the last flip, saturating at 3.
  logic [1:0] int_cnt_q, int_cnt_d;
  logic [1:0] int_eff_s;

  // Interval permission and counter next-state.
  always_comb begin
    int_eff_s = (iSWAP_INTERVAL == 2'd0) ? 2'd1 : iSWAP_INTERVAL;
    // Compare the count before this pulse plus one, in 3 bits so 3+1 cannot wrap.
    flip_ok_s = (({1'b0, int_cnt_q} + 3'd1) >= {1'b0, int_eff_s});
    if (state_q == S_FLIP) begin
      int_cnt_d = 2'd0;
    end else if (iEnd_Frame && (int_cnt_q != 2'd3)) begin
      int_cnt_d = int_cnt_q + 2'd1;
    end else begin
      int_cnt_d = int_cnt_q;
    end
  end

  // Interval counter register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      int_cnt_q <= 2'd0;
    end else begin
      int_cnt_q <= int_cnt_d;
    end
  end
`else
  // Without the interval feature every pending end-of-frame may flip.
  always_comb begin
    flip_ok_s = 1'b1;
  end
`endif

  // Flip FSM next-state and registered-output next values.
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A request coinciding with iEnd_Frame only arms; it flips next frame.
        if (iSWAP_REQ) begin
          state_d = S_PENDING;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PENDING: begin
        // Further requests are ignored here: no queueing.
        if (iEnd_Frame && flip_ok_s) begin
          state_d = S_FLIP;
        end else begin
          state_d = S_PENDING;
        end
      end
      S_FLIP: begin
        state_d = S_IDLE;
        front_d = ~front_q;
        ack_d   = 1'b1;
      end
      default: begin
        // Unreachable encoding: recover to a safe state without flipping.
        state_d = S_IDLE;
      end
    endcase
    // Registered so that it reflects the state the FSM is about to be in.
    back_ready_d = (state_d == S_IDLE);
  end

  // Read-address, strobe and frame-counter next values.
  always_comb begin
    logic [10:0]       x_s;
    logic [9:0]        y_s;
    logic [ADDR_W-1:0] base_s;
    // Coordinates arrive clamped; re-clamp defensively so a bad input can
    // never address outside the buffer.
    if (iNEXT2_X > X_MAX) begin
      x_s = X_MAX;
    end else begin
      x_s = iNEXT2_X;
    end
    if (iNEXT2_Y > Y_MAX) begin
      y_s = Y_MAX;
    end else begin
      y_s = iNEXT2_Y;
    end
    // Registered front index: a flip takes effect from the next frame start.
    if (front_q) begin
      base_s = BUF1_BASE;
    end else begin
      base_s = BUF0_BASE;
    end
    rd_addr_d = base_s + mul_stride(y_s) + {{(ADDR_W-11){1'b0}}, x_s};
    rd_en_d   = iDISPLAY_ACTIVE;
    if (iNew_Frame) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= S_IDLE;
      front_q      <= 1'b0;
      ack_q        <= 1'b0;
      back_ready_q <= 1'b1;
      rd_addr_q    <= {ADDR_W{1'b0}};
      rd_en_q      <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      ack_q        <= ack_d;
      back_ready_q <= back_ready_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign oSWAP_ACK   = ack_q;
  assign oBACK_READY = back_ready_q;
  assign oFRONT_IDX  = front_q;
  assign oBACK_IDX   = ~front_q;
  assign oRD_ADDR    = rd_addr_q;
  assign oRD_EN      = rd_en_q;
  assign oFRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_fb_flip_ctrl.sv
module tb_fb_flip_ctrl;

  logic        clk;
  logic        rst;
  logic        new_frame;
  logic        end_frame;
  logic        de;
  logic [10:0] nx;
  logic [9:0]  ny;
  logic        swap_req;
  logic        swap_ack;
  logic        back_ready;
  logic        front_idx;
  logic        back_idx;
  logic [23:0] rd_addr;
  logic        rd_en;
  logic [15:0] frame_cnt;
`ifdef FB_FLIP_INTERVAL_EN
  logic [1:0]  swap_interval;
`endif

  int checks;
  int errors;

  fb_flip_ctrl dut (
    .iCLK            (clk),
    .iRST            (rst),
    .iNew_Frame      (new_frame),
    .iEnd_Frame      (end_frame),
    .iDISPLAY_ACTIVE (de),
    .iNEXT2_X        (nx),
    .iNEXT2_Y        (ny),
`ifdef FB_FLIP_INTERVAL_EN
    .iSWAP_INTERVAL  (swap_interval),
`endif
    .iSWAP_REQ       (swap_req),
    .oSWAP_ACK       (swap_ack),
    .oBACK_READY     (back_ready),
    .oFRONT_IDX      (front_idx),
    .oBACK_IDX       (back_idx),
    .oRD_ADDR        (rd_addr),
    .oRD_EN          (rd_en),
    .oFRAME_CNT      (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fr;
    logic [10:0] x;
    logic [9:0]  y;
    logic        de;
    logic [23:0] addr;
    logic        en;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vectors(input logic fr);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].fr == fr) begin
        nx = vecs[i].x;
        ny = vecs[i].y;
        de = vecs[i].de;
        tick();
        chk($sformatf("addr_vec%0d", i), 32'(rd_addr), 32'(vecs[i].addr));
        chk($sformatf("en_vec%0d", i), 32'(rd_en), 32'(vecs[i].en));
      end
    end
    de = 1'b0;
    nx = 11'd0;
    ny = 10'd0;
  endtask

  task automatic pulse_end();
    end_frame = 1'b1;
    tick();
    end_frame = 1'b0;
  endtask

  task automatic pulse_new();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  // Watches a window of cycles, returns the ACK count and cycle of first ACK.
  task automatic watch_ack(input int budget, output int acks, output int first);
    acks  = 0;
    first = -1;
    for (int c = 0; c < budget; c++) begin
      if (swap_ack === 1'b1) begin
        acks++;
        if (first < 0) first = c;
      end
      tick();
    end
  endtask

  initial begin
    int acks;
    int first;
    logic [15:0] fc0;

    checks = 0;
    errors = 0;
    rst = 1'b1; new_frame = 1'b0; end_frame = 1'b0; de = 1'b0;
    nx = 11'd0; ny = 10'd0; swap_req = 1'b0;
`ifdef FB_FLIP_INTERVAL_EN
    swap_interval = 2'd0;
`endif

    vecs[0] = '{1'b0, 11'd0,   10'd0,   1'b1, 24'h000000, 1'b1};
    vecs[1] = '{1'b0, 11'd799, 10'd479, 1'b1, 24'h05DBFF, 1'b1};
    vecs[2] = '{1'b0, 11'd1,   10'd1,   1'b0, 24'h000321, 1'b0};
    vecs[3] = '{1'b0, 11'd10,  10'd2,   1'b1, 24'h00064A, 1'b1};
    vecs[4] = '{1'b0, 11'd799, 10'd0,   1'b1, 24'h00031F, 1'b1};
    vecs[5] = '{1'b0, 11'd0,   10'd479, 1'b1, 24'h05D8E0, 1'b1};
    vecs[6] = '{1'b1, 11'd0,   10'd0,   1'b1, 24'h060000, 1'b1};
    vecs[7] = '{1'b1, 11'd799, 10'd479, 1'b1, 24'h0BDBFF, 1'b1};
    vecs[8] = '{1'b1, 11'd5,   10'd3,   1'b1, 24'h060965, 1'b1};
    vecs[9] = '{1'b1, 11'd0,   10'd1,   1'b0, 24'h060320, 1'b0};

    // Reset defaults
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_front", 32'(front_idx), 32'd0);
    chk("rst_back", 32'(back_idx), 32'd1);
    chk("rst_ready", 32'(back_ready), 32'd1);
    chk("rst_ack", 32'(swap_ack), 32'd0);
    chk("rst_en", 32'(rd_en), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);

    // Frame counter
    pulse_new(); pulse_new(); pulse_new();
    chk("fcnt_3", 32'(frame_cnt), 32'd3);

    // Address table with front=0
    run_vectors(1'b0);

    // Basic flip
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("flip_ready_low", 32'(back_ready), 32'd0);
    tick(); tick();
    chk("flip_ready_still_low", 32'(back_ready), 32'd0);
    chk("flip_no_early_ack", 32'(swap_ack), 32'd0);
    pulse_end();
    chk("flip_c1_ack", 32'(swap_ack), 32'd0);
    chk("flip_c1_front", 32'(front_idx), 32'd0);
    chk("flip_c1_ready", 32'(back_ready), 32'd0);
    tick();
    chk("flip_c2_ack", 32'(swap_ack), 32'd1);
    chk("flip_c2_front", 32'(front_idx), 32'd1);
    chk("flip_c2_back", 32'(back_idx), 32'd0);
    chk("flip_c2_ready", 32'(back_ready), 32'd1);
    tick();
    chk("flip_c3_ack", 32'(swap_ack), 32'd0);
    pulse_new();
    nx = 11'd0; ny = 10'd0; de = 1'b1;
    tick();
    chk("flip_first_addr", 32'(rd_addr), 32'h060000);
    de = 1'b0;

    // Address table with front=1
    run_vectors(1'b1);

    // Coincident request and end-of-frame: arms only
    swap_req = 1'b1; end_frame = 1'b1; tick();
    swap_req = 1'b0; end_frame = 1'b0;
    chk("coin_ready_low", 32'(back_ready), 32'd0);
    watch_ack(4, acks, first);
    chk("coin_no_ack", 32'(acks), 32'd0);
    chk("coin_front_kept", 32'(front_idx), 32'd1);
    // Second request while pending is ignored
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pulse_end();
    watch_ack(6, acks, first);
    chk("coin_one_ack", 32'(acks), 32'd1);
    chk("coin_ack_cycle", 32'(first), 32'd1);
    chk("coin_front_toggled", 32'(front_idx), 32'd0);
    pulse_end();
    watch_ack(4, acks, first);
    chk("coin_no_second_ack", 32'(acks), 32'd0);

    // Reset while pending with front=1
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pulse_end(); tick();
    chk("rp_front1", 32'(front_idx), 32'd1);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("rp_pending", 32'(back_ready), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rp_front0", 32'(front_idx), 32'd0);
    chk("rp_back1", 32'(back_idx), 32'd1);
    chk("rp_ready", 32'(back_ready), 32'd1);
    chk("rp_fcnt", 32'(frame_cnt), 32'd0);
    pulse_end();
    watch_ack(5, acks, first);
    chk("rp_no_ack", 32'(acks), 32'd0);
    chk("rp_front_stays", 32'(front_idx), 32'd0);

`ifdef FB_FLIP_INTERVAL_EN
    // Interval=2: request right after an ACK flips on the second end-of-frame
    swap_interval = 2'd1;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pulse_end(); tick();
    chk("int_ack1", 32'(swap_ack), 32'd1);
    fc0 = frame_cnt;
    swap_interval = 2'd2;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    pulse_new();
    pulse_end();
    watch_ack(4, acks, first);
    chk("int_no_ack_first_end", 32'(acks), 32'd0);
    chk("int_still_pending", 32'(back_ready), 32'd0);
    pulse_new();
    pulse_end();
    tick();
    chk("int_ack2", 32'(swap_ack), 32'd1);
    chk("int_fcnt_delta", 32'(frame_cnt - fc0), 32'd2);
    swap_interval = 2'd0;
`else
    fc0 = frame_cnt;
    pulse_new();
    chk("fcnt_after_rst", 32'(frame_cnt - fc0), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
